// File: rtl/watch_ctrl_pkg.sv
// Shared encodings for the watch controller: modes, FSM states, BCD field limits.
// Pure declarations, no logic.
package watch_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_WATCH     = 2'b00,
      MODE_STOPWATCH = 2'b01,
      MODE_ALARM     = 2'b10,
      MODE_RSVD      = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      EDIT_HOUR = 2'b01,
      EDIT_MIN  = 2'b10,
      COMMIT    = 2'b11
   } edit_state_e;

   typedef enum logic [1:0] {
      SW_IDLE  = 2'b00,
      SW_RUN   = 2'b01,
      SW_PAUSE = 2'b10
   } sw_state_e;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX (00..MAX); clear > load > inc, one-cycle update.
// carry pulses combinationally on the increment that wraps; nxt exposes the value about to be registered.
module bcd_mod_counter
   import watch_ctrl_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       inc,
   output logic [7:0] val,
   output logic [7:0] nxt,
   output logic       carry
);

   localparam logic [7:0] MAX_BCD = to_bcd(MAX);

   always_comb begin
      nxt   = val;
      carry = 1'b0;
      if (clr) begin
         nxt = 8'h00;
      end else if (load) begin
         nxt = load_val;
      end else if (inc) begin
         if (val == MAX_BCD) begin
            nxt   = 8'h00;
            carry = 1'b1;
         end else if (val[3:0] == 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
         end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) val <= 8'h00;
      else         val <= nxt;
   end

endmodule

// File: rtl/watch_ctrl_gen.sv
// Watch/stopwatch/alarm controller with HH:MM edit FSM and beeper; disp/blankMask registered (1 cycle).
// Optional snooze on upTime while beeping when WATCH_CTRL_SNOOZE_EN is defined.
module watch_ctrl_gen
   import watch_ctrl_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int BEEP_SECS  = 30,
   parameter int SNOOZE_MIN = 5,
   localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  secTick,
   input  logic [1:0]            mode,
   input  logic                  setValue,
   input  logic                  upTime,
   input  logic [SEL_W-1:0]      alarmSel,
   input  logic                  startResume,
   input  logic                  stop,
   input  logic                  resetTime,
   output logic [15:0]           disp,
   output logic [3:0]            blankMask,
   output logic                  editing,
   output logic                  alarmBeep,
   output logic [NUM_ALARMS-1:0] alarmHit
);

   localparam logic [7:0] BEEP_LD = 8'(BEEP_SECS);

   // timekeeping
   logic [7:0] sec_val, min_val, hour_val, min_nxt, hour_nxt;
   logic       sec_carry, min_carry;
   logic [7:0] sec_nxt_unused;
   logic       hour_carry_unused;

   // edit FSM
   edit_state_e      edit_q, edit_d;
   logic             edit_enter, commit_watch, commit_alarm, mode_chg;
   logic             edit_hour_inc, edit_min_inc;
   logic             edit_is_alarm;
   logic [1:0]       edit_mode_q;
   logic [SEL_W-1:0] edit_sel_q;
   logic [7:0]       edh_val, edm_val, edh_ld, edm_ld;
   logic [7:0]       edh_nxt_unused, edm_nxt_unused;
   logic             edh_carry_unused, edm_carry_unused;

   // alarms and beeper
   logic [7:0]            alarm_h [NUM_ALARMS];
   logic [7:0]            alarm_m [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] alarm_en, match_vec, beep_hit;
   logic [7:0]            sel_h, sel_m, beep_cnt;
   logic                  beep_on, stop_beep;

   // stopwatch
   sw_state_e  sw_q, sw_d;
   logic       sw_clr, sw_sec_carry;
   logic [7:0] sw_sec_val, sw_min_val, sw_sec_nxt_unused, sw_min_nxt_unused;
   logic       sw_min_carry_unused;

   logic [15:0] disp_d;
   logic [3:0]  mask_d, field_mask;

   bcd_mod_counter #(.MAX(MIN_MAX)) u_sec (
      .clk(clk), .resetN(resetN), .clr(commit_watch), .load(1'b0), .load_val(8'h00),
      .inc(secTick), .val(sec_val), .nxt(sec_nxt_unused), .carry(sec_carry));

   bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
      .clk(clk), .resetN(resetN), .clr(1'b0), .load(commit_watch), .load_val(edm_val),
      .inc(sec_carry), .val(min_val), .nxt(min_nxt), .carry(min_carry));

   bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk(clk), .resetN(resetN), .clr(1'b0), .load(commit_watch), .load_val(edh_val),
      .inc(min_carry), .val(hour_val), .nxt(hour_nxt), .carry(hour_carry_unused));

   bcd_mod_counter #(.MAX(HOUR_MAX)) u_edit_hour (
      .clk(clk), .resetN(resetN), .clr(1'b0), .load(edit_enter), .load_val(edh_ld),
      .inc(edit_hour_inc), .val(edh_val), .nxt(edh_nxt_unused), .carry(edh_carry_unused));

   bcd_mod_counter #(.MAX(MIN_MAX)) u_edit_min (
      .clk(clk), .resetN(resetN), .clr(1'b0), .load(edit_enter), .load_val(edm_ld),
      .inc(edit_min_inc), .val(edm_val), .nxt(edm_nxt_unused), .carry(edm_carry_unused));

   bcd_mod_counter #(.MAX(MIN_MAX)) u_sw_sec (
      .clk(clk), .resetN(resetN), .clr(sw_clr), .load(1'b0), .load_val(8'h00),
      .inc(secTick && (sw_q == SW_RUN)), .val(sw_sec_val), .nxt(sw_sec_nxt_unused),
      .carry(sw_sec_carry));

   bcd_mod_counter #(.MAX(MIN_MAX)) u_sw_min (
      .clk(clk), .resetN(resetN), .clr(sw_clr), .load(1'b0), .load_val(8'h00),
      .inc(sw_sec_carry), .val(sw_min_val), .nxt(sw_min_nxt_unused),
      .carry(sw_min_carry_unused));

   always_comb begin
      sel_h = 8'h00;
      sel_m = 8'h00;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (alarmSel == SEL_W'(i)) begin
            sel_h = alarm_h[i];
            sel_m = alarm_m[i];
         end
      end
   end

   assign edh_ld = (mode == MODE_ALARM) ? sel_h : hour_val;
   assign edm_ld = (mode == MODE_ALARM) ? sel_m : min_val;

   always_comb begin
      edit_d        = edit_q;
      edit_enter    = 1'b0;
      commit_watch  = 1'b0;
      commit_alarm  = 1'b0;
      edit_hour_inc = 1'b0;
      edit_min_inc  = 1'b0;
      mode_chg      = (mode != edit_mode_q);
      case (edit_q)
         IDLE: begin
            if (setValue && (mode == MODE_WATCH || mode == MODE_ALARM)) begin
               edit_d     = EDIT_HOUR;
               edit_enter = 1'b1;
            end
         end
         EDIT_HOUR: begin
            if (mode_chg)      edit_d = IDLE;
            else if (setValue) edit_d = EDIT_MIN;
            else               edit_hour_inc = upTime;
         end
         EDIT_MIN: begin
            if (mode_chg)      edit_d = IDLE;
            else if (setValue) edit_d = COMMIT;
            else               edit_min_inc = upTime;
         end
         COMMIT: begin
            edit_d       = IDLE;
            commit_watch = !edit_is_alarm;
            commit_alarm = edit_is_alarm;
         end
         default: edit_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         edit_q        <= IDLE;
         edit_is_alarm <= 1'b0;
         edit_mode_q   <= MODE_WATCH;
         edit_sel_q    <= '0;
      end else begin
         edit_q <= edit_d;
         if (edit_enter) begin
            edit_is_alarm <= (mode == MODE_ALARM);
            edit_mode_q   <= mode;
            edit_sel_q    <= alarmSel;
         end
      end
   end

   assign editing = (edit_q != IDLE);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_h[i] <= 8'h00;
            alarm_m[i] <= 8'h00;
         end
         alarm_en <= '0;
      end else if (commit_alarm) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (edit_sel_q == SEL_W'(i)) begin
               alarm_h[i]  <= edh_val;
               alarm_m[i]  <= edm_val;
               alarm_en[i] <= 1'b1;
            end
         end
      end
   end

   // A match is the tick that rolls seconds to 00 and lands on an alarm's HH:MM.
   always_comb begin
      match_vec = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         match_vec[i] = alarm_en[i] && sec_carry && !commit_watch &&
                        (hour_nxt == alarm_h[i]) && (min_nxt == alarm_m[i]);
      end
   end

   assign stop_beep = stop && (mode != MODE_STOPWATCH);

`ifdef WATCH_CTRL_SNOOZE_EN
   localparam logic [15:0] SNZ_LD = 16'(SNOOZE_MIN * 60);

   logic                  snz_pend, snooze_req, snooze_fire;
   logic [15:0]           snz_cnt;
   logic [NUM_ALARMS-1:0] snz_hit;

   assign snooze_req  = upTime && beep_on && (edit_q == IDLE);
   assign snooze_fire = snz_pend && secTick && (snz_cnt == 16'd1);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         snz_pend <= 1'b0;
         snz_cnt  <= 16'd0;
         snz_hit  <= '0;
      end else if (stop_beep) begin
         snz_pend <= 1'b0;
      end else if (snooze_req) begin
         snz_pend <= 1'b1;
         snz_cnt  <= SNZ_LD;
         snz_hit  <= beep_hit;
      end else if (snz_pend && secTick) begin
         snz_cnt <= snz_cnt - 16'd1;
         if (snz_cnt == 16'd1) snz_pend <= 1'b0;
      end
   end
`else
   // Keeps the snooze delay parameter referenced in builds without snooze.
   logic [31:0] snooze_param_unused;
   assign snooze_param_unused = 32'(SNOOZE_MIN);
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         beep_on  <= 1'b0;
         beep_hit <= '0;
         beep_cnt <= 8'd0;
      end else if (|match_vec) begin
         beep_on  <= 1'b1;
         beep_hit <= beep_hit | match_vec;
         beep_cnt <= BEEP_LD;
      end else if (stop_beep && beep_on) begin
         beep_on  <= 1'b0;
         beep_hit <= '0;
         beep_cnt <= 8'd0;
`ifdef WATCH_CTRL_SNOOZE_EN
      end else if (snooze_req) begin
         beep_on  <= 1'b0;
         beep_hit <= '0;
         beep_cnt <= 8'd0;
      end else if (snooze_fire) begin
         beep_on  <= 1'b1;
         beep_hit <= snz_hit;
         beep_cnt <= BEEP_LD;
`endif
      end else if (secTick && beep_on) begin
         if (beep_cnt <= 8'd1) begin
            beep_on  <= 1'b0;
            beep_hit <= '0;
            beep_cnt <= 8'd0;
         end else begin
            beep_cnt <= beep_cnt - 8'd1;
         end
      end
   end

   assign alarmBeep = beep_on;
   assign alarmHit  = beep_hit;

   always_comb begin
      sw_d   = sw_q;
      sw_clr = 1'b0;
      if (mode == MODE_STOPWATCH) begin
         case (sw_q)
            SW_IDLE:  if (startResume) sw_d = SW_RUN;
            SW_RUN:   if (stop)        sw_d = SW_PAUSE;
            SW_PAUSE: begin
               if (startResume) begin
                  sw_d = SW_RUN;
               end else if (resetTime) begin
                  sw_d   = SW_IDLE;
                  sw_clr = 1'b1;
               end
            end
            default:  sw_d = SW_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) sw_q <= SW_IDLE;
      else         sw_q <= sw_d;
   end

   always_comb begin
      case (edit_q)
         EDIT_HOUR: field_mask = 4'b1100;
         EDIT_MIN:  field_mask = 4'b0011;
         default:   field_mask = 4'b0000;
      endcase
   end

   always_comb begin
      disp_d = 16'h0000;
      mask_d = 4'h0;
      case (mode)
         MODE_WATCH: begin
            disp_d = editing ? {edh_val, edm_val} : {hour_val, min_val};
            mask_d = (editing && sec_val[0]) ? field_mask : 4'h0;
         end
         MODE_ALARM: begin
            disp_d = editing ? {edh_val, edm_val} : {sel_h, sel_m};
            mask_d = (editing && sec_val[0]) ? field_mask : 4'h0;
         end
         MODE_STOPWATCH: disp_d = {sw_min_val, sw_sec_val};
         default: begin
            disp_d = 16'hFFFF;
            mask_d = 4'hF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         disp      <= 16'h0000;
         blankMask <= 4'h0;
      end else begin
         disp      <= disp_d;
         blankMask <= mask_d;
      end
   end

endmodule

// File: tb/tb_watch_ctrl_gen.sv
// Directed bench for watch_ctrl_gen: time wrap, watch/alarm edit, beep, stopwatch, abort and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_watch_ctrl_gen;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        secTick = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        setValue = 1'b0, upTime = 1'b0;
   logic [1:0]  alarmSel = 2'd0;
   logic        startResume = 1'b0, stop = 1'b0, resetTime = 1'b0;
   logic [15:0] disp;
   logic [3:0]  blankMask;
   logic        editing, alarmBeep;
   logic [3:0]  alarmHit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   watch_ctrl_gen dut (
      .clk(clk), .resetN(resetN), .secTick(secTick), .mode(mode),
      .setValue(setValue), .upTime(upTime), .alarmSel(alarmSel),
      .startResume(startResume), .stop(stop), .resetTime(resetTime),
      .disp(disp), .blankMask(blankMask), .editing(editing),
      .alarmBeep(alarmBeep), .alarmHit(alarmHit));

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic p_set();
      setValue = 1'b1; @(negedge clk); setValue = 1'b0;
   endtask
   task automatic p_up(input int n);
      repeat (n) begin upTime = 1'b1; @(negedge clk); upTime = 1'b0; end
   endtask
   task automatic p_tick(input int n);
      repeat (n) begin secTick = 1'b1; @(negedge clk); secTick = 1'b0; end
   endtask
   task automatic p_start();
      startResume = 1'b1; @(negedge clk); startResume = 1'b0;
   endtask
   task automatic p_stop();
      stop = 1'b1; @(negedge clk); stop = 1'b0;
   endtask
   task automatic p_rst();
      resetTime = 1'b1; @(negedge clk); resetTime = 1'b0;
   endtask

   task automatic test_reset();
      cyc(3);
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h exp 0000", disp); end
      checks++; if (blankMask !== 4'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", blankMask); end
      checks++; if ({editing, alarmBeep, alarmHit} !== 6'b0) begin errors++;
         $display("FAIL reset_flags got ed=%b beep=%b hit=%b exp 0", editing, alarmBeep, alarmHit); end
      resetN = 1'b1;
      cyc(2);
   endtask

   task automatic test_wrap();
      mode = 2'b00;
      p_set(); p_up(23); p_set(); p_up(59); p_set(); cyc(2);
      checks++; if (disp !== 16'h2359) begin errors++; $display("FAIL wrap_set got %h exp 2359", disp); end
      checks++; if (editing !== 1'b0) begin errors++; $display("FAIL wrap_editing got %b exp 0", editing); end
      p_tick(59);
      checks++; if (dut.sec_val !== 8'h59) begin errors++; $display("FAIL wrap_ss59 got %h exp 59", dut.sec_val); end
      p_tick(1); cyc(1);
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL wrap_disp got %h exp 0000", disp); end
      checks++; if (dut.sec_val !== 8'h00) begin errors++; $display("FAIL wrap_ss got %h exp 00", dut.sec_val); end
   endtask

   task automatic test_watch_edit();
      p_tick(3);
      p_set(); p_up(3); cyc(1);
      checks++; if (disp !== 16'h0300) begin errors++; $display("FAIL wedit_hour got %h exp 0300", disp); end
      checks++; if (blankMask !== 4'b1100) begin errors++; $display("FAIL wedit_blink_h got %b exp 1100", blankMask); end
      checks++; if (editing !== 1'b1) begin errors++; $display("FAIL wedit_editing got %b exp 1", editing); end
      p_set(); p_up(2); cyc(1);
      checks++; if (disp !== 16'h0302) begin errors++; $display("FAIL wedit_min got %h exp 0302", disp); end
      checks++; if (blankMask !== 4'b0011) begin errors++; $display("FAIL wedit_blink_m got %b exp 0011", blankMask); end
      p_tick(1); cyc(1);
      checks++; if (blankMask !== 4'b0000) begin errors++; $display("FAIL wedit_blink_even got %b exp 0000", blankMask); end
      p_set();
      p_tick(1); cyc(1);
      checks++; if (disp !== 16'h0302) begin errors++; $display("FAIL wedit_commit got %h exp 0302", disp); end
      checks++; if (dut.sec_val !== 8'h00) begin errors++; $display("FAIL wedit_ss got %h exp 00", dut.sec_val); end
      checks++; if (editing !== 1'b0) begin errors++; $display("FAIL wedit_idle got %b exp 0", editing); end
   endtask

   task automatic test_alarm_beep();
      mode = 2'b10; alarmSel = 2'd0; cyc(1);
      p_set(); p_up(7); p_set(); p_up(30); p_set(); cyc(2);
      checks++; if (disp !== 16'h0730) begin errors++; $display("FAIL alarm0_set got %h exp 0730", disp); end
      alarmSel = 2'd2;
      p_set(); alarmSel = 2'd1; p_up(7); p_set(); p_up(30); p_set(); cyc(2);
      alarmSel = 2'd2; cyc(2);
      checks++; if (disp !== 16'h0730) begin errors++; $display("FAIL alarm2_set got %h exp 0730", disp); end
      alarmSel = 2'd1; cyc(2);
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL alarm1_untouched got %h exp 0000", disp); end
      p_set(); p_up(7); p_set(); p_up(31); p_set(); cyc(2);
      checks++; if (disp !== 16'h0731) begin errors++; $display("FAIL alarm1_set got %h exp 0731", disp); end
      mode = 2'b00; alarmSel = 2'd0; cyc(1);
      p_set(); p_up(4); p_set(); p_up(27); p_set(); cyc(2);
      checks++; if (disp !== 16'h0729) begin errors++; $display("FAIL time_0729 got %h exp 0729", disp); end
      p_tick(59);
      checks++; if (alarmBeep !== 1'b0) begin errors++; $display("FAIL beep_early got %b exp 0", alarmBeep); end
      p_tick(1);
      checks++; if (alarmBeep !== 1'b1) begin errors++; $display("FAIL beep_on got %b exp 1", alarmBeep); end
      checks++; if (alarmHit !== 4'b0101) begin errors++; $display("FAIL beep_hit got %b exp 0101", alarmHit); end
      for (int i = 1; i < 30; i++) begin
         p_tick(1);
         checks++; if (alarmBeep !== 1'b1 || alarmHit !== 4'b0101) begin errors++;
            $display("FAIL beep_hold tick %0d got beep=%b hit=%b exp 1/0101", i, alarmBeep, alarmHit); end
      end
      p_tick(1);
      checks++; if (alarmBeep !== 1'b0 || alarmHit !== 4'b0000) begin errors++;
         $display("FAIL beep_expire got beep=%b hit=%b exp 0/0000", alarmBeep, alarmHit); end
      p_tick(29);
      p_tick(1);
      checks++; if (alarmBeep !== 1'b1 || alarmHit !== 4'b0010) begin errors++;
         $display("FAIL beep2_on got beep=%b hit=%b exp 1/0010", alarmBeep, alarmHit); end
`ifdef WATCH_CTRL_SNOOZE_EN
      p_up(1);
      checks++; if (alarmBeep !== 1'b0 || alarmHit !== 4'b0000) begin errors++;
         $display("FAIL snooze_off got beep=%b hit=%b exp 0/0000", alarmBeep, alarmHit); end
      p_tick(299);
      checks++; if (alarmBeep !== 1'b0) begin errors++; $display("FAIL snooze_early got %b exp 0", alarmBeep); end
      p_tick(1);
      checks++; if (alarmBeep !== 1'b1 || alarmHit !== 4'b0010) begin errors++;
         $display("FAIL snooze_refire got beep=%b hit=%b exp 1/0010", alarmBeep, alarmHit); end
`else
      p_up(1);
      checks++; if (alarmBeep !== 1'b1) begin errors++; $display("FAIL up_ignored got %b exp 1", alarmBeep); end
`endif
      mode = 2'b01; p_stop();
      checks++; if (alarmBeep !== 1'b1) begin errors++; $display("FAIL stop_in_sw got %b exp 1", alarmBeep); end
      mode = 2'b00; p_stop();
      checks++; if (alarmBeep !== 1'b0 || alarmHit !== 4'b0000) begin errors++;
         $display("FAIL stop_beep got beep=%b hit=%b exp 0/0000", alarmBeep, alarmHit); end
   endtask

   task automatic test_abort_and_collide();
      mode = 2'b10; alarmSel = 2'd0; cyc(1);
      p_set(); p_up(1); p_set();
      mode = 2'b01; cyc(1);
      checks++; if (editing !== 1'b0) begin errors++; $display("FAIL abort_editing got %b exp 0", editing); end
      mode = 2'b10; cyc(2);
      checks++; if (disp !== 16'h0730) begin errors++; $display("FAIL abort_alarm got %h exp 0730", disp); end
      p_set();
      setValue = 1'b1; upTime = 1'b1; cyc(1); setValue = 1'b0; upTime = 1'b0; cyc(1);
      checks++; if (disp !== 16'h0730) begin errors++; $display("FAIL collide_hour got %h exp 0730", disp); end
      p_up(1); cyc(1);
      checks++; if (disp !== 16'h0731) begin errors++; $display("FAIL collide_state got %h exp 0731", disp); end
      mode = 2'b00; cyc(1);
      mode = 2'b10; cyc(2);
      checks++; if (disp !== 16'h0730) begin errors++; $display("FAIL collide_nocommit got %h exp 0730", disp); end
   endtask

   task automatic test_stopwatch();
      mode = 2'b01; cyc(1);
      p_start(); p_tick(5); p_stop(); cyc(1);
      checks++; if (disp !== 16'h0005) begin errors++; $display("FAIL sw_pause got %h exp 0005", disp); end
      p_rst(); cyc(1);
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL sw_reset got %h exp 0000", disp); end
      p_start(); p_tick(2); p_rst(); p_tick(1); cyc(1);
      checks++; if (disp !== 16'h0003) begin errors++; $display("FAIL sw_run_rst got %h exp 0003", disp); end
   endtask

   task automatic test_reserved_mode();
      mode = 2'b11; cyc(2);
      checks++; if (disp !== 16'hFFFF || blankMask !== 4'hF) begin errors++;
         $display("FAIL mode11 got disp=%h mask=%h exp FFFF/F", disp, blankMask); end
   endtask

   task automatic test_async_reset();
      mode = 2'b00; cyc(1);
      p_set(); p_up(1);
      checks++; if (editing !== 1'b1) begin errors++; $display("FAIL ares_pre got %b exp 1", editing); end
      #2 resetN = 1'b0;
      #1;
      checks++; if (editing !== 1'b0 || disp !== 16'h0000 || alarmBeep !== 1'b0) begin errors++;
         $display("FAIL ares_now got ed=%b disp=%h beep=%b exp 0/0000/0", editing, disp, alarmBeep); end
      cyc(2); resetN = 1'b1; cyc(2);
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL ares_time got %h exp 0000", disp); end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_watch_edit();
      test_alarm_beep();
      test_abort_and_collide();
      test_stopwatch();
      test_reserved_mode();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/watch_ctrl_gen.md
WATCH_CTRL_GEN -- requirements
Module: watch_ctrl_gen

Interface
REQ-001 The block SHALL have one clock, `clk`, and an asynchronous, active-low reset, `resetN`.
REQ-002 Parameter `NUM_ALARMS`, default 4: number of independent alarm channels (1..8).
REQ-003 Parameter `BEEP_SECS`, default 30: beep duration in seconds (1..255).
REQ-004 Parameter `SNOOZE_MIN`, default 5: snooze delay in minutes; used only when snooze is compiled in.
REQ-005 Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  async active-low reset.
- `secTick`  in  1  one-cycle pulse, once per second.
- `mode`  in  2  00 WATCH, 01 STOPWATCH, 10 ALARM, 11 reserved.
- `setValue`  in  1  one-cycle pulse: enter or advance edit.
- `upTime`  in  1  one-cycle pulse: increment the edited field.
- `alarmSel`  in  max(1,$clog2(NUM_ALARMS))  selects the alarm channel.
- `startResume`, `stop`, `resetTime`  in  1 each  one-cycle button pulses.
- `disp`  out  16  four BCD digits, [15:12] = d3 .. [3:0] = d0.
- `blankMask`  out  4  1 = blank that digit.
- `editing`  out  1  edit FSM is not IDLE.
- `alarmBeep`  out  1  beeper drive.
- `alarmHit`  out  NUM_ALARMS  channels that caused the current beep.

Function
REQ-006 Timekeeping SHALL hold BCD HH:MM:SS (00..23, 00..59, 00..59); each `secTick` increments it with carry; 23:59:59 -> 00:00:00.
REQ-007 The edit FSM SHALL have states IDLE, EDIT_HOUR, EDIT_MIN, COMMIT.
- IDLE + `setValue` with `mode` WATCH or ALARM -> EDIT_HOUR, snapshotting HH:MM of the current time or of alarm[`alarmSel`].
REQ-008 `upTime` in EDIT_HOUR SHALL increment the edit hour (23 -> 00); in EDIT_MIN it SHALL increment the edit minute (59 -> 00); there is no carry between fields.
REQ-009 `setValue` SHALL step EDIT_HOUR -> EDIT_MIN -> COMMIT; COMMIT lasts exactly one cycle, then -> IDLE.
REQ-010 In COMMIT the block SHALL write the edit regs:
- WATCH target: HH:MM updated, SS forced to 00.
- ALARM target: alarm[sel] written and its enable set.
REQ-011 A `mode` change while editing SHALL abort to IDLE with no commit; `alarmSel` SHALL be sampled only on entry to edit.
REQ-012 If `setValue` and `upTime` arrive in the same cycle, `setValue` wins and `upTime` is dropped.
REQ-013 Time SHALL keep running during a WATCH edit; on commit the edited value overwrites it, even if `secTick` coincides with COMMIT.
REQ-014 Alarm match SHALL occur when the time advances (via `secTick`) to HH:MM:00 equal to an enabled alarm. On match:
- `alarmBeep` = 1 from the next cycle;
- the matching `alarmHit` bits are set (several alarms matching the same minute give one beep, all bits set);
- the beep counter is loaded with `BEEP_SECS`.
REQ-015 The beep counter SHALL decrement on each `secTick`; at 0, `alarmBeep` and `alarmHit` clear.
- `stop` while beeping, with `mode` != STOPWATCH, clears them next cycle.
- A match occurring during an active beep reloads the counter and ORs in the new hit bits.
REQ-016 Stopwatch SHALL count MM:SS on `secTick`, with FSM SW_IDLE, SW_RUN, SW_PAUSE; buttons act only when `mode` = STOPWATCH.
- `startResume`: IDLE/PAUSE -> RUN.
- `stop`: RUN -> PAUSE.
- `resetTime`: PAUSE -> IDLE with 00:00; ignored in RUN.
REQ-017 Stopwatch 59:59 + tick SHALL -> 00:00 and keep running; it runs in the background under any mode.
REQ-018 `disp` and `blankMask` SHALL be registered, showing state one cycle later:
- WATCH: HHMM, or edit regs while editing.
- ALARM: alarm[`alarmSel`] HHMM, or edit regs while editing.
- STOPWATCH: MMSS.
- mode 11: `disp` = 16'hFFFF, `blankMask` = 4'hF.
REQ-019 While editing, the two digits of the active field SHALL be blanked when the SS LSB is 1 (1 Hz blink); all other digits are unblanked.

Reset
REQ-020 While `resetN` = 0, the block SHALL hold:
- time 00:00:00, all alarms 00:00 and disabled;
- both FSMs idle, stopwatch 00:00, beep counter 0;
- `disp` = 0, `blankMask` = 0, `editing` = 0, `alarmBeep` = 0, `alarmHit` = 0.
REQ-021 Reset asserted mid-edit or mid-beep SHALL discard the edit and silence the beep immediately (asynchronously).

Configuration
REQ-022 Macro `WATCH_CTRL_SNOOZE_EN` defined: `upTime` while beeping and the edit FSM is IDLE SHALL silence the beep and re-fire it once after `SNOOZE_MIN` minutes (counted on `secTick`) with the same hit bits; `stop` cancels a pending snooze.
REQ-023 Macro undefined: `upTime` outside edit SHALL be ignored, no snooze logic SHALL exist, and `SNOOZE_MIN` SHALL be unused.

Structure
REQ-024 Package `watch_ctrl_pkg` SHALL hold the mode encodings, the edit and stopwatch state typedefs, and the BCD limit constants (23, 59).
REQ-025 Sub-module `bcd_mod_counter` (parametrised modulus; inc/clear/load; carry out) SHALL implement every time, alarm-edit and stopwatch field.

Verification
REQ-026 Bench SHALL cover these directed scenarios:
- Time at 23:59:59, one `secTick` -> `disp` = 0000 and time 00:00:00.
- WATCH: `setValue`, 3x `upTime`, `setValue`, 2x `upTime`, `setValue` -> `disp` shows 0302 after COMMIT and SS = 00.
- Alarms 0 and 2 both set to 07:30; time reaches 07:30:00 -> `alarmBeep` = 1, `alarmHit` = 4'b0101 for exactly 30 `secTick`s.
- Stopwatch: start, 5 ticks, `stop`, `resetTime` -> `disp` 0005 then 0000; `resetTime` while running -> no effect.
- In EDIT_MIN, switch `mode` to STOPWATCH -> `editing` = 0, alarm unchanged; same-cycle `setValue` + `upTime` in EDIT_HOUR -> hour unchanged, state EDIT_MIN.
- With the snooze macro, `upTime` while beeping -> beep off, returns after 300 ticks with the same hit bits.
